// File: rtl/mod_barrett_param_gen_32b_if.sv
// Handshake and result bundle between the Barrett parameter generator and its controller.
// The master side requests computations; the slave side (the generator) returns K/U.
interface mod_barrett_param_gen_32b_if #(
    parameter int DW = 32
);
    localparam int KW = $clog2(DW) + 1;

    logic              iEn;
    logic              iClr;
    logic              iStart;
    logic [DW-1:0]     iMod;
    logic              oBusy;
    logic              oDone;
    logic              oErr;
    logic              oValid;
    logic [KW-1:0]     oK;
    logic [2*DW-1:0]   oU;

    modport master (
        output iEn, iClr, iStart, iMod,
        input  oBusy, oDone, oErr, oValid, oK, oU
    );

    modport slave (
        input  iEn, iClr, iStart, iMod,
        output oBusy, oDone, oErr, oValid, oK, oU
    );
endinterface

// File: rtl/mod_barrett_param_gen_32b.sv
// Barrett constant generator: K = bitlen(M), U = floor(2^(2K)/M) via a restoring divider,
// one quotient bit per cycle. Results are held until the next computation completes.
//
// state  | meaning
// IDLE   | waiting for iStart, results held
// NORM   | priority-encode K from captured M, prime divider
// DIV    | 2K+1 restoring-divide iterations, MSB of dividend first
// DONE   | oDone (and oErr for M=0) asserted, results just updated
module mod_barrett_param_gen_32b #(
    parameter int DW = 32
) (
    input  logic                          iClk,
    input  logic                          iRstN,
    mod_barrett_param_gen_32b_if.slave    bus
);
    localparam int KW = $clog2(DW) + 1;
    localparam int CW = KW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NORM = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    mod_q, mod_d;
    logic [KW-1:0]    k_q, k_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DW:0]      r_q, r_d;
    logic [2*DW-1:0]  q_q, q_d;
    logic             err_q, err_d;
    logic [KW-1:0]    ok_q, ok_d;
    logic [2*DW-1:0]  ou_q, ou_d;
    logic             valid_q, valid_d;

    logic [KW-1:0]    msb_k;
    logic             div_bit;
    logic [DW+1:0]    r_shift;
    logic             sub_ge;
    logic [DW:0]      r_sub;
    logic [DW:0]      r_next;
    logic [2*DW-1:0]  q_next;

    always_comb begin
        msb_k = '0;
        for (int i = 0; i < DW; i++) begin
            if (mod_q[i]) msb_k = KW'(i + 1);
        end
    end

    // Dividend 2^(2K) is a single 1 followed by 2K zeros; the 1 lands on the first iteration.
    always_comb begin
        div_bit = (cnt_q == {k_q, 1'b1});
        r_shift = {r_q, div_bit};
        sub_ge  = (r_shift >= {2'b00, mod_q});
        // When subtracting, the result is below M, so the low DW+1 bits are exact.
        r_sub   = r_shift[DW:0] - {1'b0, mod_q};
        r_next  = sub_ge ? r_sub : r_shift[DW:0];
        q_next  = (q_q << 1) | {{(2*DW-1){1'b0}}, sub_ge};
    end

    always_comb begin
        state_d = state_q;
        mod_d   = mod_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        err_d   = err_q;
        ok_d    = ok_q;
        ou_d    = ou_q;
        valid_d = valid_q;

        if (bus.iClr) begin
            state_d = S_IDLE;
            mod_d   = '0;
            k_d     = '0;
            cnt_d   = '0;
            r_d     = '0;
            q_d     = '0;
            err_d   = 1'b0;
            ok_d    = '0;
            ou_d    = '0;
            valid_d = 1'b0;
        end else if (bus.iEn) begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.iStart) begin
                        mod_d   = bus.iMod;
                        valid_d = 1'b0;
                        state_d = S_NORM;
                    end
                end
                S_NORM: begin
                    if (mod_q == '0) begin
                        ok_d    = '0;
                        ou_d    = '1;
                        err_d   = 1'b1;
                        valid_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        k_d     = msb_k;
                        cnt_d   = {msb_k, 1'b1};
                        r_d     = '0;
                        q_d     = '0;
                        err_d   = 1'b0;
                        state_d = S_DIV;
                    end
                end
                S_DIV: begin
                    r_d   = r_next;
                    q_d   = q_next;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        ok_d    = k_q;
                        ou_d    = q_next;
                        valid_d = 1'b1;
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q <= S_IDLE;
            mod_q   <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            err_q   <= 1'b0;
            ok_q    <= '0;
            ou_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mod_q   <= mod_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            err_q   <= err_d;
            ok_q    <= ok_d;
            ou_q    <= ou_d;
            valid_q <= valid_d;
        end
    end

    // oDone follows the DONE state so a stall there stretches nothing but holds the pulse.
    assign bus.oBusy  = (state_q != S_IDLE);
    assign bus.oDone  = (state_q == S_DONE);
    assign bus.oErr   = (state_q == S_DONE) && err_q;
    assign bus.oValid = valid_q;
    assign bus.oK     = ok_q;
    assign bus.oU     = ou_q;
endmodule

// File: tb/tb_mod_barrett_param_gen_32b.sv
// Bench for the Barrett parameter generator: fixed vector table, corner sequences,
// randomised moduli with stalls; expected results travel through a scoreboard queue.
module tb_mod_barrett_param_gen_32b;
    typedef struct {
        logic [31:0] mod;
        logic [5:0]  k;
        logic [63:0] u;
        logic        err;
        int          lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    exp_t sb[$];
    exp_t tbl[6];

    mod_barrett_param_gen_32b_if #(.DW(32)) bus();

    mod_barrett_param_gen_32b #(.DW(32)) dut (
        .iClk  (clk),
        .iRstN (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] m);
        exp_t        e;
        logic [31:0] v;
        logic [127:0] u;
        int          k;
        v = m;
        k = 0;
        while (v != 0) begin
            v = v >> 1;
            k++;
        end
        e.mod = m;
        if (m == 0) begin
            e.k   = 6'd0;
            e.u   = '1;
            e.err = 1'b1;
            e.lat = 2;
        end else begin
            u     = (128'd1 << (2 * k)) / {96'd0, m};
            e.k   = 6'(k);
            e.u   = u[63:0];
            e.err = 1'b0;
            e.lat = 2 * k + 3;
        end
        return e;
    endfunction

    // Software Barrett reduction using the generated K/U, at most two corrections.
    task automatic barrett_check(input logic [31:0] m);
        logic [127:0] a, b, x, q, r;
        int k;
        for (int j = 0; j < 5; j++) begin
            k = int'(bus.oK);
            a = {96'd0, $urandom % m};
            b = {96'd0, $urandom % m};
            x = a * b;
            q = ((x >> (k - 1)) * {64'd0, bus.oU}) >> (k + 1);
            r = x - q * {96'd0, m};
            if (r >= {96'd0, m}) r = r - {96'd0, m};
            if (r >= {96'd0, m}) r = r - {96'd0, m};
            check("barrett_mod", r, x % {96'd0, m});
        end
    endtask

    // mode: 0 no stalls, 1 random iEn gaps + iMod noise, 2 seven-cycle DIV stall + DONE stall,
    // 3 second iStart with iMod=3 while busy
    task automatic run(input logic [31:0] m, input exp_t e, input int mode);
        exp_t got;
        int   c;
        int   stalls;
        bit   done;
        @(negedge clk);
        bus.iMod   = m;
        bus.iStart = 1'b1;
        bus.iEn    = 1'b1;
        sb.push_back(e);
        c      = 0;
        stalls = 0;
        done   = 0;
        while (!done && c < 300) begin
            @(negedge clk);
            c++;
            if (c == 1) begin
                check("busy_after_start", {127'd0, bus.oBusy}, 128'd1);
                check("valid_cleared", {127'd0, bus.oValid}, 128'd0);
            end
            if (bus.oDone) begin
                done       = 1;
                bus.iStart = 1'b0;
                bus.iEn    = 1'b1;
            end else begin
                bus.iStart = (mode == 3 && c == 5);
                if (mode == 3 && c == 5) bus.iMod = 32'd3;
                if (mode == 1) begin
                    bus.iEn  = ($urandom_range(0, 3) != 0);
                    bus.iMod = $urandom;
                end else if (mode == 2) begin
                    bus.iEn = !(c >= 10 && c < 17);
                end else begin
                    bus.iEn = 1'b1;
                end
                if (!bus.iEn) stalls++;
            end
        end
        if (!done) check("done_timeout", 128'd0, 128'd1);
        got = sb.pop_front();
        check("oK", {122'd0, bus.oK}, {122'd0, got.k});
        check("oU", {64'd0, bus.oU}, {64'd0, got.u});
        check("oErr", {127'd0, bus.oErr}, {127'd0, got.err});
        check("oValid", {127'd0, bus.oValid}, 128'd1);
        check("latency", 128'(c), 128'(got.lat + stalls));
        if (mode == 2) begin
            bus.iEn = 1'b0;
            @(negedge clk);
            check("done_hold_1", {127'd0, bus.oDone}, 128'd1);
            @(negedge clk);
            check("done_hold_2", {127'd0, bus.oDone}, 128'd1);
            bus.iEn = 1'b1;
        end
        @(negedge clk);
        check("done_single", {127'd0, bus.oDone}, 128'd0);
        check("idle_after", {127'd0, bus.oBusy}, 128'd0);
        check("oK_held", {122'd0, bus.oK}, {122'd0, got.k});
    endtask

    initial begin
        exp_t        e;
        logic [31:0] m;
        bit          saw;

        n_tests = 0;
        n_fail  = 0;
        tbl[0] = '{32'd7681,       6'd13, 64'd8736,                1'b0, 29};
        tbl[1] = '{32'hFFFF_FFFF,  6'd32, 64'h0000_0001_0000_0001, 1'b0, 67};
        tbl[2] = '{32'd1,          6'd1,  64'd4,                   1'b0, 5};
        tbl[3] = '{32'h8000_0000,  6'd32, 64'h0000_0002_0000_0000, 1'b0, 67};
        tbl[4] = '{32'd0,          6'd0,  64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2};
        tbl[5] = '{32'd12289,      6'd14, 64'd21843,               1'b0, 31};

        bus.iEn    = 1'b0;
        bus.iClr   = 1'b0;
        bus.iStart = 1'b0;
        bus.iMod   = '0;
        rst_n      = 1'b1;
        #2 rst_n   = 1'b0;
        #1;
        check("rst_busy", {127'd0, bus.oBusy}, 128'd0);
        check("rst_done", {127'd0, bus.oDone}, 128'd0);
        check("rst_valid", {127'd0, bus.oValid}, 128'd0);
        check("rst_oK", {122'd0, bus.oK}, 128'd0);
        check("rst_oU", {64'd0, bus.oU}, 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run(tbl[i].mod, tbl[i], 0);
            if (tbl[i].mod == 32'hFFFF_FFFF || tbl[i].mod == 32'd7681) barrett_check(tbl[i].mod);
        end

        run(32'd7681, tbl[0], 3);
        run(32'd7681, tbl[0], 2);

        // Asynchronous reset in the middle of a computation.
        @(negedge clk);
        bus.iMod   = 32'd7681;
        bus.iStart = 1'b1;
        @(negedge clk);
        bus.iStart = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_busy", {127'd0, bus.oBusy}, 128'd0);
        check("arst_valid", {127'd0, bus.oValid}, 128'd0);
        check("arst_oK", {122'd0, bus.oK}, 128'd0);
        check("arst_oU", {64'd0, bus.oU}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(32'd12289, tbl[5], 0);

        // Synchronous clear mid-DIV: abort with no oDone.
        @(negedge clk);
        bus.iMod   = 32'd7681;
        bus.iStart = 1'b1;
        @(negedge clk);
        bus.iStart = 1'b0;
        repeat (8) @(negedge clk);
        bus.iClr = 1'b1;
        @(negedge clk);
        bus.iClr = 1'b0;
        check("clr_busy", {127'd0, bus.oBusy}, 128'd0);
        check("clr_valid", {127'd0, bus.oValid}, 128'd0);
        check("clr_oK", {122'd0, bus.oK}, 128'd0);
        check("clr_oU", {64'd0, bus.oU}, 128'd0);
        saw = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.oDone) saw = 1;
        end
        check("clr_no_done", {127'd0, saw}, 128'd0);

        // Clear and start together: the start is dropped.
        bus.iMod   = 32'd7681;
        bus.iStart = 1'b1;
        bus.iClr   = 1'b1;
        @(negedge clk);
        bus.iStart = 1'b0;
        bus.iClr   = 1'b0;
        check("clr_start_busy", {127'd0, bus.oBusy}, 128'd0);

        for (int i = 0; i < 200; i++) begin
            m = $urandom >> $urandom_range(0, 31);
            if (m == 0) m = 32'd1;
            e = model(m);
            run(m, e, 1);
        end

        check("scoreboard_empty", 128'(sb.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
